// File: rtl/rr_burst_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package rr_burst_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Pointer increment modulo n, wrapping n-1 back to 0.
  function automatic int ptrInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational N-way rotating-priority picker: the first set request at or
// after ptr_i (ascending, modulo N) wins.
module rr_prio_pick #(
  parameter int N   = 3,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   win_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  always_comb begin
    int idx;
    idx   = 0;
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) idx = idx - N;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        win_o[idx] = 1'b1;
        idx_o      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-requester round-robin arbiter that locks the grant for a whole burst.
// Define RR_BURST_ARB_TIMEOUT_EN to add the stall-timeout release and o_timeout.
module rr_burst_arbiter
  import rr_burst_arb_pkg::*;
#(
  parameter int N = 3,
`ifdef RR_BURST_ARB_TIMEOUT_EN
  parameter int MAX_HOLD = 16,
`endif
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           asrst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_last,
  input  logic           gnt_ready,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_grant_id,
  output logic           o_grant_vld,
  output logic           o_busy
`ifdef RR_BURST_ARB_TIMEOUT_EN
  ,
  output logic           o_timeout
`endif
);

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [N-1:0]   pickWin;
  logic [IDW-1:0] pickIdx;
  logic           pickAny;
  logic [IDW-1:0] pickPtr;
  logic [IDW-1:0] ptrNext;
  logic           beatAcc;
  logic           releaseNow;

`ifdef RR_BURST_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
`endif

  // At release the picker already sees the rotated pointer, so a new winner
  // can be registered in the same cycle without an idle bubble.
  assign ptrNext = IDW'(ptrInc(int'(id_q), N));
  assign pickPtr = (state_q == BUSY) ? ptrNext : ptr_q;

  rr_prio_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_i (req),
    .ptr_i (pickPtr),
    .win_o (pickWin),
    .idx_o (pickIdx),
    .any_o (pickAny)
  );

  always_ff @(posedge clk or negedge asrst_n) begin
    if (!asrst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
`ifdef RR_BURST_ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
`ifdef RR_BURST_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    beatAcc    = (state_q == BUSY) && gnt_ready && req[id_q];
    releaseNow = beatAcc && req_last[id_q];
`ifdef RR_BURST_ARB_TIMEOUT_EN
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    // A stalled burst is forced out as if its last beat had been accepted.
    if ((state_q == BUSY) && !beatAcc) begin
      if (hold_q == HW'(MAX_HOLD - 1)) begin
        releaseNow = 1'b1;
        timeout_d  = 1'b1;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
`endif
    case (state_q)
      IDLE: begin
        if (en && pickAny) begin
          state_d = BUSY;
          grant_d = pickWin;
          id_d    = pickIdx;
`ifdef RR_BURST_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      BUSY: begin
        if (releaseNow) begin
          ptr_d = ptrNext;
`ifdef RR_BURST_ARB_TIMEOUT_EN
          hold_d = '0;
`endif
          if (en && pickAny) begin
            grant_d = pickWin;
            id_d    = pickIdx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  always_comb begin
    o_grant     = grant_q;
    o_grant_id  = id_q;
    o_grant_vld = |grant_q;
    o_busy      = (state_q == BUSY);
`ifdef RR_BURST_ARB_TIMEOUT_EN
    o_timeout   = timeout_q;
`endif
  end

endmodule
